// File: rtl/cd_pkg.sv
// Shared constants and helpers for the cd_* receive-path blocks.
package cd_pkg;

    localparam int CD_BYTE_W          = 8;
    localparam int CD_FRAME_BYTES_DEF = 256;

    // Ceiling log2 used for address and count widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cd_dpram.sv
// Simple dual-port RAM: one write port, one enabled synchronous read port,
// no reset, read-before-write on address collision.
module cd_dpram #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/cd_rx_fifo.sv
// Frame-slot receive FIFO: writer fills a slot then commits it with switch,
// reader walks the head slot and pops it. Optional macro: CD_RX_FIFO_ERR_EN.
module cd_rx_fifo
    import cd_pkg::*;
#(
    parameter int SLOTS       = 4,
    parameter int FRAME_BYTES = CD_FRAME_BYTES_DEF,
    parameter int CW          = clog2(SLOTS + 1),
    localparam int AW         = clog2(FRAME_BYTES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [CD_BYTE_W-1:0] wr_byte,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 wr_en,
    input  logic [7:0]           wr_len,
    input  logic                 wr_err,
    input  logic                 switch,
    output logic                 switch_fail,
    input  logic                 rd_en,
    input  logic [AW-1:0]        rd_addr,
    output logic [CD_BYTE_W-1:0] rd_byte,
    output logic [7:0]           rd_len,
    output logic                 rd_err,
    input  logic                 rd_done,
    input  logic                 rd_done_all,
    output logic                 unread,
    output logic [CW-1:0]        unread_len
);

    localparam int          PW       = clog2(SLOTS);
    localparam logic [CW-1:0] FULL_CNT = CW'(SLOTS);

    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [CW-1:0]        count_reg;
    logic [CW-1:0]        count_next;
    logic                 switch_fail_reg;
    logic                 rd_valid_reg;
    logic [CD_BYTE_W-1:0] ram_rdata;
    logic [7:0]           len_mem [SLOTS];

    logic pop;
    logic push;
    logic fail;

    // Pop is resolved before push so a full FIFO can accept a commit in the
    // same cycle its head is released; a flush overrides both.
    always_comb begin
        pop        = 1'b0;
        push       = 1'b0;
        fail       = 1'b0;
        count_next = count_reg;
        if (!rd_done_all) begin
            pop  = rd_done && (count_reg != '0);
            push = switch && ((count_reg != FULL_CNT) || pop);
            fail = switch && (count_reg == FULL_CNT) && !pop;
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            switch_fail_reg <= 1'b0;
            rd_valid_reg    <= 1'b0;
        end else begin
            switch_fail_reg <= fail;
            if (rd_en) begin
                rd_valid_reg <= 1'b1;
            end
            if (rd_done_all) begin
                rd_ptr_reg <= wr_ptr_reg;
                count_reg  <= '0;
            end else begin
                count_reg <= count_next;
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            len_mem[wr_ptr_reg] <= wr_len;
        end
    end

`ifdef CD_RX_FIFO_ERR_EN
    logic err_mem [SLOTS];

    always_ff @(posedge clk) begin
        if (push) begin
            err_mem[wr_ptr_reg] <= wr_err;
        end
    end

    assign rd_err = err_mem[rd_ptr_reg];
`else
    logic unused_wr_err;

    assign unused_wr_err = wr_err;
    assign rd_err        = 1'b0;
`endif

    cd_dpram #(
        .DW (CD_BYTE_W),
        .AW (PW + AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_ptr_reg, wr_addr}),
        .wdata (wr_byte),
        .re    (rd_en),
        .raddr ({rd_ptr_reg, rd_addr}),
        .rdata (ram_rdata)
    );

    // The RAM output register has no reset, so mask it until the first read.
    assign rd_byte     = rd_valid_reg ? ram_rdata : '0;
    assign switch_fail = switch_fail_reg;
    assign rd_len      = len_mem[rd_ptr_reg];
    assign unread      = (count_reg != '0);
    assign unread_len  = count_reg;

endmodule

// File: tb/tb_cd_rx_fifo.sv
// Directed bench for cd_rx_fifo with SLOTS=4, FRAME_BYTES=256.
module tb_cd_rx_fifo;

    localparam int SLOTS = 4;
    localparam int FB    = 256;
    localparam int AW    = 8;
    localparam int CW    = 3;

`ifdef CD_RX_FIFO_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    wr_byte;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [7:0]    wr_len;
    logic          wr_err;
    logic          switch;
    logic          switch_fail;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_byte;
    logic [7:0]    rd_len;
    logic          rd_err;
    logic          rd_done;
    logic          rd_done_all;
    logic          unread;
    logic [CW-1:0] unread_len;

    int checks = 0;
    int errors = 0;

    cd_rx_fifo #(
        .SLOTS       (SLOTS),
        .FRAME_BYTES (FB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_byte     (wr_byte),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .wr_len      (wr_len),
        .wr_err      (wr_err),
        .switch      (switch),
        .switch_fail (switch_fail),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_byte     (rd_byte),
        .rd_len      (rd_len),
        .rd_err      (rd_err),
        .rd_done     (rd_done),
        .rd_done_all (rd_done_all),
        .unread      (unread),
        .unread_len  (unread_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_byte = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic commit(input logic [7:0] len, input logic err);
        switch = 1'b1; wr_len = len; wr_err = err;
        tick();
        switch = 1'b0; wr_err = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr);
        rd_en = 1'b1; rd_addr = addr;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pop();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; wr_byte = '0; wr_addr = '0; wr_en = 1'b0; wr_len = '0;
        wr_err = 1'b0; switch = 1'b0; rd_en = 1'b0; rd_addr = '0;
        rd_done = 1'b0; rd_done_all = 1'b0;
        #1;
        chk("rst_unread", unread, 0);
        chk("rst_unread_len", unread_len, 0);
        chk("rst_switch_fail", switch_fail, 0);
        chk("rst_rd_byte", rd_byte, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // basic frame
        for (int i = 0; i < 3; i++) wr(8'(i), 8'hA1 + 8'(i));
        commit(8'd3, 1'b0);
        chk("basic_unread_len", unread_len, 1);
        chk("basic_rd_len", rd_len, 3);
        chk("basic_fail", switch_fail, 0);
        for (int i = 0; i < 3; i++) begin
            rd(8'(i));
            chk($sformatf("basic_byte%0d", i), rd_byte, 32'hA1 + i);
        end
        tick();
        chk("basic_hold", rd_byte, 8'hA3);
        pop();
        chk("basic_empty", unread, 0);

        // fill, overflow, drain in order
        for (int k = 1; k <= 4; k++) begin
            wr(8'd0, 8'h10 + 8'(k));
            commit(8'(k), 1'b0);
        end
        chk("full_len", unread_len, 4);
        commit(8'd9, 1'b0);
        chk("ovf_fail_pulse", switch_fail, 1);
        chk("ovf_len", unread_len, 4);
        tick();
        chk("ovf_fail_clear", switch_fail, 0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("drain_len%0d", k), rd_len, k);
            rd(8'd0);
            chk($sformatf("drain_byte%0d", k), rd_byte, 32'h10 + k);
            pop();
        end
        chk("drain_empty", unread_len, 0);

        // full with simultaneous pop and switch
        for (int k = 1; k <= 4; k++) commit(8'(k), 1'b0);
        rd_done = 1'b1;
        commit(8'd5, 1'b0);
        rd_done = 1'b0;
        chk("fullpop_fail", switch_fail, 0);
        chk("fullpop_len", unread_len, 4);
        chk("fullpop_head", rd_len, 2);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("fullpop_drain%0d", k), rd_len, k);
            pop();
        end
        pop();
        chk("underflow", unread_len, 0);

        // partial fill with simultaneous pop and switch
        commit(8'd7, 1'b0);
        rd_done = 1'b1;
        commit(8'd8, 1'b0);
        rd_done = 1'b0;
        chk("mid_len", unread_len, 1);
        chk("mid_head", rd_len, 8);
        pop();

        // flush with simultaneous switch
        for (int k = 1; k <= 3; k++) commit(8'(k), 1'b0);
        rd_done_all = 1'b1;
        commit(8'd9, 1'b0);
        rd_done_all = 1'b0;
        chk("flush_len", unread_len, 0);
        chk("flush_fail", switch_fail, 0);
        wr(8'd5, 8'h66);
        commit(8'd6, 1'b0);
        chk("postflush_len", unread_len, 1);
        chk("postflush_rdlen", rd_len, 6);
        rd(8'd5);
        chk("postflush_byte", rd_byte, 8'h66);
        pop();

        // flush while full with switch must not flag a failure
        for (int k = 1; k <= 4; k++) commit(8'(k), 1'b0);
        rd_done_all = 1'b1;
        commit(8'd9, 1'b0);
        rd_done_all = 1'b0;
        chk("fullflush_fail", switch_fail, 0);
        chk("fullflush_len", unread_len, 0);

        // read-during-write returns old data (write slot == head slot when empty)
        wr(8'd3, 8'h11);
        wr_en = 1'b1; wr_addr = 8'd3; wr_byte = 8'h22;
        rd_en = 1'b1; rd_addr = 8'd3;
        tick();
        wr_en = 1'b0;
        chk("rdw_old", rd_byte, 8'h11);
        tick();
        rd_en = 1'b0;
        chk("rdw_new", rd_byte, 8'h22);

        // ten push/pop rounds wrap the pointers
        for (int n = 0; n < 10; n++) begin
            wr(8'(n), 8'h30 + 8'(n));
            wr(8'hFF, 8'hC0 + 8'(n));
            commit(8'(n + 20), 1'b0);
            chk($sformatf("wrap%0d_cnt", n), unread_len, 1);
            chk($sformatf("wrap%0d_len", n), rd_len, n + 20);
            rd(8'(n));
            chk($sformatf("wrap%0d_b0", n), rd_byte, 32'h30 + n);
            rd(8'hFF);
            chk($sformatf("wrap%0d_b1", n), rd_byte, 32'hC0 + n);
            pop();
        end
        pop();
        chk("wrap_underflow", unread_len, 0);

        // error flag
        commit(8'd1, 1'b1);
        chk("err_flag", rd_err, ERR_EXP);
        pop();

        // asynchronous reset mid-frame with a pending failure pulse
        for (int k = 1; k <= 4; k++) commit(8'(k), 1'b0);
        rd(8'd5);
        wr_en = 1'b1; wr_addr = 8'd1; wr_byte = 8'h77;
        commit(8'd9, 1'b0);
        wr_en = 1'b0;
        chk("prerst_fail", switch_fail, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_unread", unread, 0);
        chk("arst_fail", switch_fail, 0);
        chk("arst_rd_byte", rd_byte, 0);
        tick();
        reset_n = 1'b1;
        commit(8'd4, 1'b0);
        chk("postrst_len", unread_len, 1);
        chk("postrst_rdlen", rd_len, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
